// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;

    typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} mem_src_e;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_HOLD = 1'b1} arb_state_e;

    function automatic mem_src_e other_src(input mem_src_e s);
        return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Records which requester owns each granted-but-unanswered transaction,
// so in-order responses can be steered back to their issuer.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  mem_src_e                     src_i,
    input  logic                         pop_i,
    output mem_src_e                     head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    mem_src_e            mem_q [Depth];
    mem_src_e            mem_d [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = src_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= SRC_INSTR;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one req/gnt/rvalid memory port between the
// instruction-fetch and LSU requesters, with in-order response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AddrWidth      = BUS_AW,
    parameter int unsigned DataWidth      = BUS_DW,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 instr_req_i,
    input  logic [AddrWidth-1:0] instr_addr_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    output logic [DataWidth-1:0] instr_rdata_o,
    output logic                 instr_err_o,
    input  logic                 data_req_i,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_err_o,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic                 mem_err_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q, state_d;
    mem_src_e        sel_q, sel_d;
    mem_src_e        rr_q, rr_d;
    mem_src_e        winner, sel, head;
    logic            fifo_full, fifo_empty, grant, pop;
    logic [CntW-1:0] count;

    // rr_q names the source that wins the next tie.
    always_comb begin
        winner = SRC_INSTR;
        if (instr_req_i && data_req_i) winner = rr_q;
        else if (data_req_i)           winner = SRC_DATA;
    end

    assign sel       = (state_q == ARB_HOLD) ? sel_q : winner;
    assign mem_req_o = rst_ni & ((state_q == ARB_HOLD) |
                                 ((instr_req_i | data_req_i) & ~fifo_full));
    assign grant       = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = grant & (sel == SRC_INSTR);
    assign data_gnt_o  = grant & (sel == SRC_DATA);

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel == SRC_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o = instr_addr_i;
                mem_be_o   = 4'hF;
            end
        end
    end

    // A response with nothing outstanding is silently dropped.
    assign pop            = mem_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = pop & (head == SRC_INSTR);
    assign data_rvalid_o  = pop & (head == SRC_DATA);
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = rst_ni ? mem_rdata_i : '0;
    assign data_rdata_o   = rst_ni ? mem_rdata_i : '0;

    mem_arb_id_fifo #(.Depth(MaxOutstanding)) u_id_fifo (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .src_i   (sel),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: if (mem_req_o && !mem_gnt_i) begin
                state_d = ARB_HOLD;
                sel_d   = winner;
            end
            ARB_HOLD: if (mem_gnt_i) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        if (grant) rr_d = other_src(sel);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            sel_q   <= SRC_DATA;
            rr_q    <= SRC_DATA;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

`ifndef SYNTHESIS
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_ni)
        !(mem_rvalid_i && fifo_empty))
        else $warning("mem_port_arbiter: response with no outstanding transaction dropped");
    a_no_rvalid_on_first_grant: assert property (@(posedge clk) disable iff (!rst_ni)
        !(mem_rvalid_i && grant && count == '0))
        else $warning("mem_port_arbiter: response coincides with first grant");
    a_instr_req_held: assert property (@(posedge clk) disable iff (!rst_ni)
        (instr_req_i && !instr_gnt_o) |=> instr_req_i)
        else $error("mem_port_arbiter: instr request withdrawn before grant");
    a_data_req_held: assert property (@(posedge clk) disable iff (!rst_ni)
        (data_req_i && !data_gnt_o) |=> data_req_i)
        else $error("mem_port_arbiter: data request withdrawn before grant");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector tables plus a
// randomized run against a queue-based model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int MAX = 2;
    localparam logic [31:0] IADDR = 32'h8000_0000;
    localparam logic [31:0] DADDR = 32'h0000_0100;
    localparam logic [31:0] DWDAT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, data_req_i, data_we_i;
    logic [31:0] instr_addr_i, data_addr_i, data_wdata_i;
    logic [3:0]  data_be_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] instr_rdata_o, data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(MAX)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    typedef struct {
        logic        ireq, dreq, gnt, rv, err;
        logic [31:0] rdata;
        logic        ignt, dgnt, irv, drv, ierr, derr, mreq, we;
        logic [31:0] addr;
    } vec_t;

    vec_t vq[$];

    // iv = {ireq,dreq,gnt,rvalid,err}; ex = {ignt,dgnt,irv,drv,ierr,derr,mreq,we}
    function automatic vec_t mk(input logic [4:0] iv, input logic [31:0] rdata,
                                input logic [7:0] ex, input logic [31:0] addr);
        vec_t v;
        {v.ireq, v.dreq, v.gnt, v.rv, v.err} = iv;
        v.rdata = rdata;
        {v.ignt, v.dgnt, v.irv, v.drv, v.ierr, v.derr, v.mreq, v.we} = ex;
        v.addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_zero();
        instr_req_i = 0; data_req_i = 0; instr_addr_i = 0; data_addr_i = 0;
        data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".mem_req"}, 32'(mem_req_o), 0);
        chk({tag, ".mem_addr"}, mem_addr_o, 0);
        chk({tag, ".gnts"}, 32'({instr_gnt_o, data_gnt_o}), 0);
        chk({tag, ".rvalids"}, 32'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}), 0);
    endtask

    // Assumed to be entered just after a rising edge; leaves just after one.
    task automatic do_reset();
        rst_ni = 0;
        drive_zero();
        instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        #2;
        check_all_zero("reset");
        drive_zero();
        @(posedge clk);
        #2 rst_ni = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        instr_req_i = v.ireq; data_req_i = v.dreq;
        instr_addr_i = IADDR; data_addr_i = DADDR;
        data_we_i = 1'b1; data_be_i = 4'hF; data_wdata_i = DWDAT;
        mem_gnt_i = v.gnt; mem_rvalid_i = v.rv; mem_err_i = v.err; mem_rdata_i = v.rdata;
        #4;
        chk({tag, ".instr_gnt"}, 32'(instr_gnt_o), 32'(v.ignt));
        chk({tag, ".data_gnt"}, 32'(data_gnt_o), 32'(v.dgnt));
        chk({tag, ".mem_req"}, 32'(mem_req_o), 32'(v.mreq));
        chk({tag, ".mem_addr"}, mem_addr_o, v.addr);
        chk({tag, ".mem_we"}, 32'(mem_we_o), 32'(v.we));
        chk({tag, ".mem_be"}, 32'(mem_be_o), v.mreq ? 32'hF : 32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata_o, v.we ? DWDAT : 32'h0);
        chk({tag, ".instr_rvalid"}, 32'(instr_rvalid_o), 32'(v.irv));
        chk({tag, ".data_rvalid"}, 32'(data_rvalid_o), 32'(v.drv));
        chk({tag, ".instr_err"}, 32'(instr_err_o), 32'(v.ierr));
        chk({tag, ".data_err"}, 32'(data_err_o), 32'(v.derr));
        if (v.irv || v.drv) begin
            chk({tag, ".instr_rdata"}, instr_rdata_o, v.rdata);
            chk({tag, ".data_rdata"}, data_rdata_o, v.rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string name);
        for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("%s[%0d]", name, i));
        vq.delete();
    endtask

    initial begin
        rst_ni = 0;
        drive_zero();
        @(posedge clk);
        #1;

        // Contention with immediate grants, then the outstanding limit.
        do_reset();
        vq.push_back(mk(5'b11100, 0, 8'b01000011, DADDR));
        vq.push_back(mk(5'b11110, 0, 8'b10010010, IADDR));
        vq.push_back(mk(5'b11110, 0, 8'b01100011, DADDR));
        vq.push_back(mk(5'b11110, 0, 8'b10010010, IADDR));
        vq.push_back(mk(5'b01110, 0, 8'b01100011, DADDR));
        vq.push_back(mk(5'b00010, 0, 8'b00010000, 0));
        vq.push_back(mk(5'b10100, 0, 8'b10000010, IADDR));
        vq.push_back(mk(5'b01100, 0, 8'b01000011, DADDR));
        vq.push_back(mk(5'b11100, 0, 8'b00000000, 0));
        vq.push_back(mk(5'b11110, 0, 8'b00100000, 0));
        vq.push_back(mk(5'b11100, 0, 8'b10000010, IADDR));
        vq.push_back(mk(5'b01110, 0, 8'b00010000, 0));
        vq.push_back(mk(5'b01110, 0, 8'b01100011, DADDR));
        vq.push_back(mk(5'b00010, 0, 8'b00010000, 0));
        for (int i = 0; i < vq.size(); i++) vq[i].rdata = 32'h1000 + 32'(i);
        run_seq("table");

        // Single fetch with same-cycle grant and next-cycle response.
        do_reset();
        vq.push_back(mk(5'b10100, 0, 8'b10000010, IADDR));
        vq.push_back(mk(5'b00010, 32'h13, 8'b00100000, 0));
        run_seq("fetch");

        // Delayed grant holds the instr selection against a data request.
        do_reset();
        vq.push_back(mk(5'b10000, 0, 8'b00000010, IADDR));
        vq.push_back(mk(5'b11000, 0, 8'b00000010, IADDR));
        vq.push_back(mk(5'b11000, 0, 8'b00000010, IADDR));
        vq.push_back(mk(5'b11100, 0, 8'b10000010, IADDR));
        vq.push_back(mk(5'b01100, 0, 8'b01000011, DADDR));
        vq.push_back(mk(5'b00010, 32'h1, 8'b00100000, 0));
        vq.push_back(mk(5'b00010, 32'h2, 8'b00010000, 0));
        run_seq("hold");

        // In-order responses; error only accompanies the data response.
        do_reset();
        vq.push_back(mk(5'b10100, 0, 8'b10000010, IADDR));
        vq.push_back(mk(5'b01100, 0, 8'b01000011, DADDR));
        vq.push_back(mk(5'b00010, 32'hA5A5A5A5, 8'b00100000, 0));
        vq.push_back(mk(5'b00011, 32'h5A, 8'b00010100, 0));
        vq.push_back(mk(5'b00001, 0, 8'b00000000, 0));
        run_seq("resp");

        // Reset while a transaction is outstanding, then a stray response.
        do_reset();
        apply(mk(5'b10100, 0, 8'b10000010, IADDR), "midrst.grant");
        instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        #1 rst_ni = 0;
        #1;
        check_all_zero("midrst.async");
        drive_zero();
        @(posedge clk);
        #2 rst_ni = 1;
        @(posedge clk);
        #1;
        vq.push_back(mk(5'b00010, 32'h7, 8'b00000000, 0));
        vq.push_back(mk(5'b11100, 0, 8'b01000011, DADDR));
        vq.push_back(mk(5'b10100, 0, 8'b10000010, IADDR));
        vq.push_back(mk(5'b00010, 32'h1, 8'b00010000, 0));
        vq.push_back(mk(5'b00010, 32'h2, 8'b00100000, 0));
        run_seq("midrst");

        // Randomized traffic against a queue model of outstanding owners.
        do_reset();
        begin
            logic        q[$];
            logic        last = 1'b0;
            logic        locked = 1'b0;
            logic        lock_src = 1'b0;
            logic        ir = 1'b0, dr = 1'b0, dwe = 1'b0;
            logic [31:0] ia = 0, da = 0, dw = 0;
            logic [3:0]  dbe = 0;
            logic        e_req, e_sel, e_irv, e_drv, gnt, rv, err;
            logic [31:0] rd;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (!ir && $urandom_range(0, 2) == 0) begin ir = 1; ia = $urandom; end
                if (!dr && $urandom_range(0, 2) == 0) begin
                    dr = 1; da = $urandom; dw = $urandom;
                    dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom);
                end
                gnt = 1'($urandom_range(0, 1));
                rv  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
                err = ($urandom_range(0, 3) == 0);
                rd  = $urandom;
                instr_req_i = ir; instr_addr_i = ia;
                data_req_i = dr; data_addr_i = da; data_we_i = dwe; data_be_i = dbe; data_wdata_i = dw;
                mem_gnt_i = gnt; mem_rvalid_i = rv; mem_err_i = err; mem_rdata_i = rd;
                #4;
                e_req = locked || ((q.size() < MAX) && (ir || dr));
                e_sel = locked ? lock_src : ((ir && dr) ? ~last : dr);
                e_irv = rv && (q[0] == 1'b0);
                e_drv = rv && (q[0] == 1'b1);
                chk("rnd.mem_req", 32'(mem_req_o), 32'(e_req));
                chk("rnd.instr_gnt", 32'(instr_gnt_o), 32'(e_req && gnt && !e_sel));
                chk("rnd.data_gnt", 32'(data_gnt_o), 32'(e_req && gnt && e_sel));
                chk("rnd.mem_addr", mem_addr_o, !e_req ? 0 : (e_sel ? da : ia));
                chk("rnd.mem_we", 32'(mem_we_o), 32'(e_req && e_sel && dwe));
                chk("rnd.mem_be", 32'(mem_be_o), !e_req ? 0 : (e_sel ? 32'(dbe) : 32'hF));
                chk("rnd.mem_wdata", mem_wdata_o, (e_req && e_sel) ? dw : 0);
                chk("rnd.instr_rvalid", 32'(instr_rvalid_o), 32'(e_irv));
                chk("rnd.data_rvalid", 32'(data_rvalid_o), 32'(e_drv));
                chk("rnd.instr_err", 32'(instr_err_o), 32'(e_irv && err));
                chk("rnd.data_err", 32'(data_err_o), 32'(e_drv && err));
                if (rv) chk("rnd.rdata", instr_rdata_o ^ data_rdata_o ^ rd, rd);
                if (rv) void'(q.pop_front());
                if (e_req && gnt) begin
                    q.push_back(e_sel);
                    last = e_sel;
                    locked = 1'b0;
                    if (e_sel) dr = 0; else ir = 0;
                end else if (e_req) begin
                    locked = 1'b1;
                    lock_src = e_sel;
                end
                @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
